fp32_naive_divider: RTL
=======================

Name: fp32_naive_divider

Overview:
- Sequential IEEE-754 single-precision divider computing z = a / b.
- Inverse arithmetic unit of the fp32 multiplier. Plugs into the same stb/ack streaming fabric, so it drops into any datapath slot that holds a multiplier.
- Uses a multi-cycle state machine with restoring long division, one quotient bit per cycle.
- Round-to-nearest-even; denormals are supported on both input and output.

Parameters:
- none: the format is fixed to binary32.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (block is in reset while reset==0)
- input_a  input  32  dividend
- input_a_stb  input  1  dividend valid
- input_a_ack  output  1  dividend accepted
- input_b  input  32  divisor
- input_b_stb  input  1  divisor valid
- input_b_ack  output  1  divisor accepted
- output_z  output  32  quotient
- output_z_stb  output  1  quotient valid
- output_z_ack  input  1  quotient consumed

Behaviour:
- Reset (async, reset==0):
  - state=get_a
  - input_a_ack=0, input_b_ack=0, output_z_stb=0, output_z=0
  - Reset mid-operation discards the operation in flight; the first cycle after release begins get_a.
- Handshake:
  - In get_a, input_a_ack rises one cycle after entry.
  - The word is captured on the edge where ack && stb are both 1; ack drops the next cycle; the FSM moves to get_b.
  - get_b behaves identically for b.
  - In put_z, output_z is driven with z and output_z_stb=1. On the edge where stb && output_z_ack, stb drops and the FSM returns to get_a.
  - output_z holds its last value until the next put_z.
  - A stb asserted before the ack is ignored until the ack is high. The block never accepts a and b in the same cycle.
- States and transitions:
  - get_a -> get_b -> unpack -> special_cases -> {put_z | normalise_a} -> normalise_b -> divide_0 -> divide_1 (x27) -> divide_2 -> normalise_1 -> normalise_2 -> round -> pack -> put_z.
- unpack:
  - 24-bit mantissas with bit23 = 0.
  - Exponents are 10-bit signed, equal to the field minus 127.
  - Signs are captured.
- special_cases, in priority order:
  1. Either operand NaN -> 0xFFC00000.
  2. a inf and b inf -> 0xFFC00000.
  3. a inf -> inf with sign a_s^b_s.
  4. b inf -> signed zero.
  5. b zero: if a is also zero -> 0xFFC00000; otherwise signed inf.
  6. a zero -> signed zero.
  7. Otherwise:
     - A denormal operand gets exponent -126.
     - A normal operand gets mantissa bit23 set.
- normalise_a / normalise_b: shift the mantissa left 1 and decrement the exponent each cycle until bit23=1 (up to 23 cycles each).
- divide_0:
  - z_s = a_s ^ b_s
  - z_e = a_e - b_e
  - remainder R (25 bits) = a_m
  - quotient q (27 bits) = 0
  - count = 26
- divide_1, one cycle per bit, for i = 26 down to 0:
  - if R >= b_m: q[i]=1 and R = R - b_m
  - then R = R << 1
  - exit after i=0
  - Result: q = floor(a_m·2^26 / b_m), with q[26] or q[25] set.
- divide_2:
  - z_m = q[26:3]
  - guard = q[2]
  - round_bit = q[1]
  - sticky = q[0] | (R != 0)
- normalise_1: while z_m[23]==0, shift left bringing guard into bit0, guard <= round_bit, round_bit <= 0, decrement z_e. At most one iteration in practice.
- normalise_2: while z_e < -126, shift right:
  - z_e++
  - guard <= z_m[0]
  - round_bit <= guard
  - sticky |= round_bit
- round:
  - If guard && (round_bit | sticky | z_m[0]), increment z_m.
  - If z_m was 0xFFFFFF, increment z_e.
- pack:
  - Fields are sign, z_e+127, z_m[22:0].
  - If z_e == -126 and z_m[23]==0, the exponent field is 0 (denormal).
  - If z_e > 127, the result is signed inf with mantissa 0.
- Latency: normalised-operand latency from b capture to output_z_stb is fixed, apart from the normalise_1 adjustment. Denormal inputs and underflow add cycles. Special cases bypass division and take 3 cycles from b capture to put_z.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2) -> 0x40400000; also verify stb stays high until output_z_ack is held off 5 cycles.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB (round-up via sticky); 0xC1200000 / 0x40000000 -> 0xC0A00000.
- Special cases:
  - 0x3F800000/0x00000000 -> 0x7F800000
  - 0x00000000/0x80000000 -> 0xFFC00000
  - 0xFF800000/0x40000000 -> 0xFF800000
  - 0x3F800000/0x7F800000 -> 0x00000000
  - 0x7FC00000/any -> 0xFFC00000
- Range:
  - 0x7F7FFFFF/0x00800000 -> 0x7F800000 (overflow)
  - 0x00800000/0x40000000 -> 0x00400000 (denormal output)
  - 0x00000001/0x3F000000 -> 0x00000002 (denormal input)
- Reset asserted low during divide_1 with input_a_ack/output_z_stb observed -> all outputs 0 immediately. After release, a fresh 6/2 returns 0x40400000 with no stale data.
- Randomised 10k operand pairs with random stb/ack delays vs a reference model -> bit-exact results, every input accepted exactly once.

Source files
------------

// File: rtl/fp32_naive_divider.sv
// Sequential IEEE-754 binary32 divider z = a / b using restoring long division,
// one quotient bit per cycle, round-to-nearest-even, denormals in and out.
// Ports:
//   clock, reset (async, active-low)
//   input_a / input_a_stb / input_a_ack : dividend stream
//   input_b / input_b_stb / input_b_ack : divisor stream
//   output_z / output_z_stb / output_z_ack : quotient stream
module fp32_naive_divider (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  localparam int unsigned EW = 10;  // signed working exponent
  localparam int unsigned MW = 24;  // mantissa incl. hidden bit
  localparam int unsigned QW = 27;  // quotient: 24 bits + guard/round/sticky
  localparam int unsigned RW = 25;  // partial remainder
  localparam int unsigned CW = 5;   // quotient bit index

  localparam logic signed [EW-1:0] E_MAX    = 10'sd128;
  localparam logic signed [EW-1:0] E_MIN    = -10'sd127;
  localparam logic signed [EW-1:0] DENORM_E = -10'sd126;
  localparam logic signed [EW-1:0] E_BIAS   = 10'sd127;
  localparam logic [31:0]          QNAN     = 32'hFFC0_0000;

  typedef enum logic [3:0] {
    GET_A, GET_B, UNPACK, SPECIAL_CASES, NORMALISE_A, NORMALISE_B,
    DIVIDE_0, DIVIDE_1, DIVIDE_2, NORMALISE_1, NORMALISE_2, ROUND, PACK, PUT_Z
  } state_t;

  state_t                 state, state_n;
  logic [31:0]            a, a_n, b, b_n, z, z_n, out_z_n;
  logic [MW-1:0]          a_m, a_m_n, b_m, b_m_n, z_m, z_m_n;
  logic signed [EW-1:0]   a_e, a_e_n, b_e, b_e_n, z_e, z_e_n;
  logic                   a_s, a_s_n, b_s, b_s_n, z_s, z_s_n;
  logic                   guard, guard_n, round_bit, round_bit_n, sticky, sticky_n;
  logic [QW-1:0]          q, q_n;
  logic [RW-1:0]          rem, rem_n, r_tmp;
  logic [CW-1:0]          count, count_n;
  logic                   a_ack_n, b_ack_n, z_stb_n;
  logic                   sign;

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= GET_A;
      a            <= '0;
      b            <= '0;
      z            <= '0;
      a_m          <= '0;
      b_m          <= '0;
      z_m          <= '0;
      a_e          <= '0;
      b_e          <= '0;
      z_e          <= '0;
      a_s          <= 1'b0;
      b_s          <= 1'b0;
      z_s          <= 1'b0;
      guard        <= 1'b0;
      round_bit    <= 1'b0;
      sticky       <= 1'b0;
      q            <= '0;
      rem          <= '0;
      count        <= '0;
      input_a_ack  <= 1'b0;
      input_b_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= '0;
    end else begin
      state        <= state_n;
      a            <= a_n;
      b            <= b_n;
      z            <= z_n;
      a_m          <= a_m_n;
      b_m          <= b_m_n;
      z_m          <= z_m_n;
      a_e          <= a_e_n;
      b_e          <= b_e_n;
      z_e          <= z_e_n;
      a_s          <= a_s_n;
      b_s          <= b_s_n;
      z_s          <= z_s_n;
      guard        <= guard_n;
      round_bit    <= round_bit_n;
      sticky       <= sticky_n;
      q            <= q_n;
      rem          <= rem_n;
      count        <= count_n;
      input_a_ack  <= a_ack_n;
      input_b_ack  <= b_ack_n;
      output_z_stb <= z_stb_n;
      output_z     <= out_z_n;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_n     = state;
    a_n         = a;
    b_n         = b;
    z_n         = z;
    a_m_n       = a_m;
    b_m_n       = b_m;
    z_m_n       = z_m;
    a_e_n       = a_e;
    b_e_n       = b_e;
    z_e_n       = z_e;
    a_s_n       = a_s;
    b_s_n       = b_s;
    z_s_n       = z_s;
    guard_n     = guard;
    round_bit_n = round_bit;
    sticky_n    = sticky;
    q_n         = q;
    rem_n       = rem;
    count_n     = count;
    a_ack_n     = input_a_ack;
    b_ack_n     = input_b_ack;
    z_stb_n     = output_z_stb;
    out_z_n     = output_z;
    r_tmp       = '0;
    sign        = a_s ^ b_s;

    case (state)
      GET_A: begin
        a_ack_n = 1'b1;
        if (input_a_ack && input_a_stb) begin
          a_n     = input_a;
          a_ack_n = 1'b0;
          state_n = GET_B;
        end
      end
      GET_B: begin
        b_ack_n = 1'b1;
        if (input_b_ack && input_b_stb) begin
          b_n     = input_b;
          b_ack_n = 1'b0;
          state_n = UNPACK;
        end
      end
      UNPACK: begin
        a_m_n   = {1'b0, a[22:0]};
        b_m_n   = {1'b0, b[22:0]};
        a_e_n   = $signed({2'b00, a[30:23]}) - E_BIAS;
        b_e_n   = $signed({2'b00, b[30:23]}) - E_BIAS;
        a_s_n   = a[31];
        b_s_n   = b[31];
        state_n = SPECIAL_CASES;
      end
      SPECIAL_CASES: begin
        state_n = PUT_Z;
        if ((a_e == E_MAX && a_m != '0) || (b_e == E_MAX && b_m != '0)) begin
          z_n = QNAN;
        end else if (a_e == E_MAX && b_e == E_MAX) begin
          z_n = QNAN;
        end else if (a_e == E_MAX) begin
          z_n = {sign, 8'hFF, 23'd0};
        end else if (b_e == E_MAX) begin
          z_n = {sign, 31'd0};
        end else if (b_e == E_MIN && b_m == '0) begin
          z_n = (a_e == E_MIN && a_m == '0) ? QNAN : {sign, 8'hFF, 23'd0};
        end else if (a_e == E_MIN && a_m == '0) begin
          z_n = {sign, 31'd0};
        end else begin
          // Denormals keep the minimum exponent; normals regain the hidden bit
          if (a_e == E_MIN) a_e_n = DENORM_E;
          else              a_m_n[MW-1] = 1'b1;
          if (b_e == E_MIN) b_e_n = DENORM_E;
          else              b_m_n[MW-1] = 1'b1;
          state_n = NORMALISE_A;
        end
      end
      NORMALISE_A: begin
        if (a_m[MW-1]) begin
          state_n = NORMALISE_B;
        end else begin
          a_m_n = {a_m[MW-2:0], 1'b0};
          a_e_n = a_e - 10'sd1;
        end
      end
      NORMALISE_B: begin
        if (b_m[MW-1]) begin
          state_n = DIVIDE_0;
        end else begin
          b_m_n = {b_m[MW-2:0], 1'b0};
          b_e_n = b_e - 10'sd1;
        end
      end
      DIVIDE_0: begin
        z_s_n   = sign;
        z_e_n   = a_e - b_e;
        rem_n   = {1'b0, a_m};
        q_n     = '0;
        count_n = CW'(QW - 1);
        state_n = DIVIDE_1;
      end
      DIVIDE_1: begin
        // Restoring step: one quotient bit, then shift the partial remainder
        r_tmp = rem;
        if (rem >= {1'b0, b_m}) begin
          q_n[count] = 1'b1;
          r_tmp      = rem - {1'b0, b_m};
        end
        rem_n = r_tmp << 1;
        if (count == '0) state_n = DIVIDE_2;
        else             count_n = count - 5'd1;
      end
      DIVIDE_2: begin
        z_m_n       = q[QW-1:3];
        guard_n     = q[2];
        round_bit_n = q[1];
        sticky_n    = q[0] | (rem != '0);
        state_n     = NORMALISE_1;
      end
      NORMALISE_1: begin
        if (!z_m[MW-1]) begin
          z_m_n       = {z_m[MW-2:0], guard};
          guard_n     = round_bit;
          round_bit_n = 1'b0;
          z_e_n       = z_e - 10'sd1;
        end else begin
          state_n = NORMALISE_2;
        end
      end
      NORMALISE_2: begin
        // Denormalise results below the minimum normal exponent
        if (z_e < DENORM_E) begin
          z_e_n       = z_e + 10'sd1;
          z_m_n       = z_m >> 1;
          guard_n     = z_m[0];
          round_bit_n = guard;
          sticky_n    = sticky | round_bit;
        end else begin
          state_n = ROUND;
        end
      end
      ROUND: begin
        if (guard && (round_bit | sticky | z_m[0])) begin
          z_m_n = z_m + 24'd1;
          if (z_m == 24'hFF_FFFF) z_e_n = z_e + 10'sd1;
        end
        state_n = PACK;
      end
      PACK: begin
        z_n[22:0]  = z_m[22:0];
        z_n[30:23] = 8'(z_e + E_BIAS);
        z_n[31]    = z_s;
        if (z_e == DENORM_E && !z_m[MW-1]) z_n[30:23] = 8'd0;
        if (z_e > E_BIAS) z_n = {z_s, 8'hFF, 23'd0};
        state_n = PUT_Z;
      end
      PUT_Z: begin
        z_stb_n = 1'b1;
        out_z_n = z;
        if (output_z_stb && output_z_ack) begin
          z_stb_n = 1'b0;
          state_n = GET_A;
        end
      end
      default: state_n = GET_A;
    endcase
  end

endmodule
